// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns single-cycle RAM load/store requests from the memory
// stage into AXI4-Lite master transactions, one request at a time.
// A combined store+load is serialised store first.
// Optional feature macro: LSU_AXI_ERR_EN adds a sticky err_o flag that sets on
// any non-OKAY rresp/bresp handshake.
//
// state          | meaning
// ---------------+---------------------------------------------------
// S_IDLE         | waiting for ram_wen_i / ram_ren_i
// S_WR_ADDR_DATA | AW and W channels outstanding, each drops on its own
// S_WR_RESP      | waiting for B response
// S_RD_ADDR      | AR channel outstanding
// S_RD_DATA      | waiting for R data
// S_DONE         | one-cycle done pulse, still busy
module lsu_axi_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ram_ren_i,
  input  logic                ram_wen_i,
  input  logic [ADDR_W-1:0]   ram_raddr_i,
  input  logic [ADDR_W-1:0]   ram_waddr_i,
  input  logic [DATA_W-1:0]   ram_wdata_i,
  input  logic [DATA_W-1:0]   ram_wmask_i,
  output logic [DATA_W-1:0]   ram_rdata_o,
  output logic                axi_busy_o,
  output logic                done_o,
`ifdef LSU_AXI_ERR_EN
  output logic                err_o,
`endif
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_araddr, r_awaddr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [2:0]          r_rd_off;
  logic                r_rd_pend;
  logic                r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
  logic                r_busy, r_done;

  logic [DATA_W/8-1:0] w_bmask;
  logic [2:0]          w_woff;
  logic [DATA_W/8-1:0] w_wstrb;
  logic [DATA_W-1:0]   w_wdata_sh;
  logic [DATA_W-1:0]   w_rdata_sh;
  logic                w_aw_ok, w_w_ok;
  logic                w_unused;

  // Byte-enable per lane from the bit mask, then lane alignment of store/load
  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < DATA_W/8; i++) w_bmask[i] = ram_wmask_i[8*i];
  end

  assign w_woff     = ram_waddr_i[2:0];
  assign w_wstrb    = w_bmask << w_woff;
  assign w_wdata_sh = ram_wdata_i << {w_woff, 3'b000};
  assign w_rdata_sh = rdata >> {r_rd_off, 3'b000};
  // A write channel counts as finished once its valid is gone or is being accepted
  assign w_aw_ok    = !r_awvalid || awready;
  assign w_w_ok     = !r_wvalid  || wready;

  // Request sequencer; all AXI controls and handshake outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_araddr  <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_rd_off  <= '0;
      r_rd_pend <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ram_ren_i) begin
            r_araddr <= {ram_raddr_i[ADDR_W-1:3], 3'b000};
            r_rd_off <= ram_raddr_i[2:0];
          end
          if (ram_wen_i) begin
            r_awaddr  <= {ram_waddr_i[ADDR_W-1:3], 3'b000};
            r_wdata   <= w_wdata_sh;
            r_wstrb   <= w_wstrb;
            r_rd_pend <= ram_ren_i;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_WR_ADDR_DATA;
          end else if (ram_ren_i) begin
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_RD_ADDR;
          end
        end
        S_WR_ADDR_DATA: begin
          if (r_awvalid && awready) r_awvalid <= 1'b0;
          if (r_wvalid && wready)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_bready <= 1'b0;
            if (r_rd_pend) begin
              r_rd_pend <= 1'b0;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= w_rdata_sh;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LSU_AXI_ERR_EN
  logic r_err;

  // Sticky error on any non-OKAY response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_err <= 1'b0;
    else if ((r_bready && bvalid && (bresp != 2'b00)) ||
             (r_rready && rvalid && (rresp != 2'b00)))
      r_err <= 1'b1;
  end

  assign err_o    = r_err;
  assign w_unused = ^ram_wmask_i;
`else
  assign w_unused = ^{ram_wmask_i, rresp, bresp};
`endif

  assign araddr      = r_araddr;
  assign arvalid     = r_arvalid;
  assign rready      = r_rready;
  assign awaddr      = r_awaddr;
  assign awvalid     = r_awvalid;
  assign wdata       = r_wdata;
  assign wstrb       = r_wstrb;
  assign wvalid      = r_wvalid;
  assign bready      = r_bready;
  assign ram_rdata_o = r_rdata;
  assign axi_busy_o  = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Testbench for lsu_axi_bridge: directed requests, a configurable AXI slave,
// and a scoreboard monitor that checks every handshake and done pulse.
module tb_lsu_axi_bridge;

  logic        clk, rst;
  logic        ram_ren_i, ram_wen_i;
  logic [63:0] ram_raddr_i, ram_waddr_i, ram_wdata_i, ram_wmask_i;
  logic [63:0] ram_rdata_o;
  logic        axi_busy_o, done_o;
`ifdef LSU_AXI_ERR_EN
  logic        err_o;
`endif
  logic [63:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [7:0]  wstrb;

  lsu_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ram_ren_i(ram_ren_i), .ram_wen_i(ram_wen_i),
    .ram_raddr_i(ram_raddr_i), .ram_waddr_i(ram_waddr_i),
    .ram_wdata_i(ram_wdata_i), .ram_wmask_i(ram_wmask_i),
    .ram_rdata_o(ram_rdata_o), .axi_busy_o(axi_busy_o), .done_o(done_o),
`ifdef LSU_AXI_ERR_EN
    .err_o(err_o),
`endif
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard queues
  logic [63:0] q_aw[$], q_wd[$], q_ws[$], q_ar[$], q_dr[$];
  int          q_dc[$];
  logic [63:0] exp_hold = 64'h0;
  int          s_edge = 0;

  // slave configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        r_hold = 1'b0;
  logic [63:0] rdata_val = 64'h0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // AXI slave: drives responses just after the falling edge
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk); #1;
      if (awvalid) begin aw_cnt++; awready = (aw_cnt > aw_dly); end
      else begin aw_cnt = 0; awready = 0; end
      if (wvalid) begin w_cnt++; wready = (w_cnt > w_dly); end
      else begin w_cnt = 0; wready = 0; end
      if (arvalid) begin ar_cnt++; arready = (ar_cnt > ar_dly); end
      else begin ar_cnt = 0; arready = 0; end
      bvalid = bready;
      bresp  = bresp_val;
      rvalid = rready && !r_hold;
      rdata  = rdata_val;
      rresp  = rresp_val;
    end
  end

  // Monitor: every handshake and done pulse pops and checks an expectation
  initial begin
    forever begin
      @(negedge clk); #2;
      if (awvalid && awready) begin
        if (q_aw.size() == 0) chk("unexpected_aw", 64'd1, 64'd0);
        else chk("awaddr", awaddr, q_aw.pop_front());
      end
      if (wvalid && wready) begin
        if (q_wd.size() == 0) chk("unexpected_w", 64'd1, 64'd0);
        else begin
          chk("wdata", wdata, q_wd.pop_front());
          chk("wstrb", {56'h0, wstrb}, q_ws.pop_front());
        end
      end
      if (arvalid && arready) begin
        if (q_ar.size() == 0) chk("unexpected_ar", 64'd1, 64'd0);
        else chk("araddr", araddr, q_ar.pop_front());
      end
      if (done_o) begin
        if (q_dr.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          chk("ram_rdata_o", ram_rdata_o, q_dr.pop_front());
          chk("done_cycle", 64'(cyc), 64'(q_dc.pop_front()));
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic ren, input logic [63:0] waddr,
                       input logic [63:0] wd, input logic [63:0] wm, input logic [63:0] raddr);
    @(negedge clk); #3;
    ram_wen_i = wen; ram_ren_i = ren;
    ram_waddr_i = waddr; ram_wdata_i = wd; ram_wmask_i = wm; ram_raddr_i = raddr;
    s_edge = cyc + 1;
    @(posedge clk); #1;
    ram_wen_i = 0; ram_ren_i = 0;
  endtask

  // return just after the monitor sample of cycle k (cycle 1 follows the sample edge)
  task automatic wait_k(input int k);
    do @(negedge clk); while (cyc < s_edge + k - 1);
    #3;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #3;
      if (!axi_busy_o) break;
    end
    chk("idle_timeout", {63'h0, axi_busy_o}, 64'd0);
  endtask

  task automatic do_load(input logic [63:0] raddr, input logic [63:0] srd,
                         input logic [63:0] e_ar, input logic [63:0] e_rd, input int k);
    rdata_val = srd;
    q_ar.push_back(e_ar);
    issue(1'b0, 1'b1, 64'h0, 64'h0, 64'h0, raddr);
    q_dr.push_back(e_rd);
    q_dc.push_back(s_edge + k - 1);
    exp_hold = e_rd;
  endtask

  task automatic do_store(input logic [63:0] waddr, input logic [63:0] wd, input logic [63:0] wm,
                          input logic [63:0] e_aw, input logic [63:0] e_wd, input logic [63:0] e_ws,
                          input int k);
    q_aw.push_back(e_aw); q_wd.push_back(e_wd); q_ws.push_back(e_ws);
    issue(1'b1, 1'b0, waddr, wd, wm, 64'h0);
    q_dr.push_back(exp_hold);
    q_dc.push_back(s_edge + k - 1);
  endtask

  initial begin
    rst = 1; ram_ren_i = 0; ram_wen_i = 0;
    ram_raddr_i = 0; ram_waddr_i = 0; ram_wdata_i = 0; ram_wmask_i = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", {63'h0, axi_busy_o}, 64'd0);
    chk("rst_done", {63'h0, done_o}, 64'd0);
    chk("rst_valids", {59'h0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
    chk("rst_rdata", ram_rdata_o, 64'd0);
    chk("rst_addr", araddr | awaddr, 64'd0);
    chk("rst_wdata", wdata, 64'd0);
    chk("rst_wstrb", {56'h0, wstrb}, 64'd0);
`ifdef LSU_AXI_ERR_EN
    chk("rst_err", {63'h0, err_o}, 64'd0);
`endif
    rst = 0;

    // zero-wait load with offset 4
    do_load(64'h8000_0004, 64'h1122_3344_5566_7788, 64'h8000_0000, 64'h0000_0000_1122_3344, 3);
    wait_k(1); chk("ld_busy_c1", {63'h0, axi_busy_o}, 64'd1);
    chk("ld_arvalid_c1", {63'h0, arvalid}, 64'd1);
    wait_k(2); chk("ld_busy_c2", {63'h0, axi_busy_o}, 64'd1);
    wait_k(3); chk("ld_busy_c3", {63'h0, axi_busy_o}, 64'd1);
    chk("ld_done_c3", {63'h0, done_o}, 64'd1);
    wait_k(4); chk("ld_busy_c4", {63'h0, axi_busy_o}, 64'd0);
    chk("ld_done_c4", {63'h0, done_o}, 64'd0);

    // store sizes and lane placement
    do_store(64'h8000_0013, 64'hAB, 64'hff, 64'h8000_0010, 64'h0000_0000_AB00_0000, 64'h08, 3);
    wait_idle();
    do_store(64'h8000_0006, 64'hBEEF, 64'hffff, 64'h8000_0000, 64'hBEEF_0000_0000_0000, 64'hC0, 3);
    wait_idle();
    do_store(64'hA000_0004, 64'h1234_5678, 64'hffff_ffff, 64'hA000_0000, 64'h1234_5678_0000_0000, 64'hF0, 3);
    wait_idle();
    do_store(64'h8000_0020, 64'h0102_0304_0506_0708, 64'hffff_ffff_ffff_ffff, 64'h8000_0020,
             64'h0102_0304_0506_0708, 64'hFF, 3);
    wait_idle();

    // loads with other offsets
    do_load(64'h8000_0007, 64'hA1B2_C3D4_E5F6_0718, 64'h8000_0000, 64'h0000_0000_0000_00A1, 3);
    wait_idle();
    do_load(64'h8000_000A, 64'hA1B2_C3D4_E5F6_0718, 64'h8000_0008, 64'h0000_A1B2_C3D4_E5F6, 3);
    wait_idle();

    // skewed ready: AW at +1, W at +4
    w_dly = 3;
    do_store(64'h8000_0008, 64'h55, 64'hff, 64'h8000_0008, 64'h55, 64'h01, 6);
    wait_k(1); chk("sk_awvalid_c1", {63'h0, awvalid}, 64'd1);
    wait_k(2); chk("sk_awvalid_c2", {63'h0, awvalid}, 64'd0);
    chk("sk_wvalid_c2", {63'h0, wvalid}, 64'd1);
    wait_k(4); chk("sk_wvalid_c4", {63'h0, wvalid}, 64'd1);
    chk("sk_bready_c4", {63'h0, bready}, 64'd0);
    wait_k(5); chk("sk_wvalid_c5", {63'h0, wvalid}, 64'd0);
    chk("sk_bready_c5", {63'h0, bready}, 64'd1);
    wait_idle();
    w_dly = 0;

    // reverse skew: W first, AW at +3
    aw_dly = 2;
    do_store(64'h8000_0019, 64'h66, 64'hff, 64'h8000_0018, 64'h0000_0000_0000_6600, 64'h02, 5);
    wait_k(2); chk("rs_wvalid_c2", {63'h0, wvalid}, 64'd0);
    chk("rs_awvalid_c2", {63'h0, awvalid}, 64'd1);
    wait_idle();
    aw_dly = 0;

    // combined store + load, same address
    rdata_val = 64'h0807_0605_0403_0201;
    q_aw.push_back(64'h8000_0010); q_wd.push_back(64'h0000_0077_0000_0000); q_ws.push_back(64'h10);
    q_ar.push_back(64'h8000_0010);
    issue(1'b1, 1'b1, 64'h8000_0014, 64'h77, 64'hff, 64'h8000_0014);
    q_dr.push_back(64'h0000_0000_0807_0605);
    q_dc.push_back(s_edge + 4);
    exp_hold = 64'h0000_0000_0807_0605;
    wait_k(1); chk("cb_arvalid_c1", {63'h0, arvalid}, 64'd0);
    wait_k(2); chk("cb_arvalid_c2", {63'h0, arvalid}, 64'd0);
    chk("cb_bready_c2", {63'h0, bready}, 64'd1);
    wait_k(3); chk("cb_arvalid_c3", {63'h0, arvalid}, 64'd1);
    wait_k(4); chk("cb_done_c4", {63'h0, done_o}, 64'd0);
    wait_k(5); chk("cb_done_c5", {63'h0, done_o}, 64'd1);
    wait_idle();

    // a store request while busy must be ignored
    do_load(64'h8000_0040, 64'hDEAD_BEEF_0000_0001, 64'h8000_0040, 64'hDEAD_BEEF_0000_0001, 3);
    wait_k(2);
    ram_wen_i = 1; ram_waddr_i = 64'h8000_0050; ram_wdata_i = 64'h99; ram_wmask_i = 64'hff;
    wait_k(3);
    ram_wen_i = 0;
    wait_k(4); chk("ign_busy_c4", {63'h0, axi_busy_o}, 64'd0);
    chk("ign_awvalid_c4", {63'h0, awvalid}, 64'd0);
    wait_k(5); chk("ign_awvalid_c5", {63'h0, awvalid}, 64'd0);

    // reset while waiting in RD_DATA
    r_hold = 1;
    q_ar.push_back(64'h8000_0008);
    issue(1'b0, 1'b1, 64'h0, 64'h0, 64'h0, 64'h8000_000C);
    wait_k(2); chk("rr_rready_c2", {63'h0, rready}, 64'd1);
    #1 rst = 1;
    #1;
    chk("rr_arvalid", {63'h0, arvalid}, 64'd0);
    chk("rr_rready", {63'h0, rready}, 64'd0);
    chk("rr_busy", {63'h0, axi_busy_o}, 64'd0);
    chk("rr_rdata", ram_rdata_o, 64'd0);
    @(negedge clk); #3;
    rst = 0; r_hold = 0; exp_hold = 64'h0;

    // recovery load after reset
    do_load(64'h8000_0001, 64'h0000_0000_0000_BB00, 64'h8000_0000, 64'h0000_0000_0000_00BB, 3);
    wait_idle();

`ifdef LSU_AXI_ERR_EN
    bresp_val = 2'b10;
    do_store(64'h8000_0030, 64'h01, 64'hff, 64'h8000_0030, 64'h01, 64'h01, 3);
    wait_k(2); chk("err_c2", {63'h0, err_o}, 64'd0);
    wait_k(3); chk("err_c3", {63'h0, err_o}, 64'd1);
    wait_idle();
    bresp_val = 2'b00;
    do_load(64'h8000_0030, 64'h1234, 64'h8000_0030, 64'h1234, 3);
    wait_k(4); chk("err_sticky", {63'h0, err_o}, 64'd1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    #3;
    chk("sb_empty", 64'(q_aw.size() + q_wd.size() + q_ar.size() + q_dr.size() + q_dc.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_axi_bridge.md
# lsu_axi_bridge

Converts the single-cycle RAM request interface driven by the memory-access stage into AXI4-Lite master transactions. It returns load data and a busy/done handshake to that stage and to pipeline control. It sits between the memory-access stage's `ram_*` outputs and the system AXI4-Lite interconnect (RAM plus MMIO at and above 0xa000_0000). It handles one request at a time. A combined store and load in the same cycle is serialised with the store first.

## Interface
Parameters:
- `ADDR_W`, 64, AXI address width
- `DATA_W`, 64, AXI data width; fixed at 64, the only supported value

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ram_ren_i`  in  1  load request; sampled only in IDLE
- `ram_wen_i`  in  1  store request; sampled only in IDLE
- `ram_raddr_i`  in  64  load byte address
- `ram_waddr_i`  in  64  store byte address
- `ram_wdata_i`  in  64  store data, right-aligned (LSB = byte at address)
- `ram_wmask_i`  in  64  bit mask: 0xff, 0xffff, 0xffff_ffff or all-ones
- `ram_rdata_o`  out  64  load data, right-aligned; held until the next load completes
- `axi_busy_o`  out  1  transaction in flight; feeds the memory stage's `axi_busy_i`
- `done_o`  out  1  one-cycle pulse when the whole request has completed
- `araddr/arvalid/arready`, `rdata/rresp/rvalid/rready`: AXI4-Lite read channels, 64-bit address and data, 2-bit resp
- `awaddr/awvalid/awready`, `wdata/wstrb/wvalid/wready`, `bresp/bvalid/bready`: AXI4-Lite write channels; `wstrb` is 8 bits
- `err_o`  out  1  sticky error; present only with `LSU_AXI_ERR_EN`

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- **IDLE**
  - If `ram_wen_i`: latch the store fields, and latch the load fields if `ram_ren_i` is also high; go to WR_ADDR_DATA.
  - Else if `ram_ren_i`: latch the load fields; go to RD_ADDR.
  - Else remain in IDLE.
- **WR_ADDR_DATA**
  - `awvalid` and `wvalid` both assert on entry.
  - Each valid drops independently after its own handshake.
  - Move to WR_RESP once both handshakes have occurred; they may complete in the same cycle or in either order.
- **WR_RESP**
  - `bready` = 1.
  - On `bvalid`: go to RD_ADDR if a load is pending, else DONE.
- **RD_ADDR**: `arvalid` = 1; on `arready`, go to RD_DATA.
- **RD_DATA**: `rready` = 1; on `rvalid`, capture data into `ram_rdata_o` and go to DONE.
- **DONE**: `done_o` = 1 for one cycle; go to IDLE.
- Address and lane rules, with `off` = addr[2:0]:
  - `awaddr`/`araddr` = {addr[63:3], 3'b0}.
  - `wstrb` = (byte mask from `ram_wmask_i` bits 0, 8, …, 56) << `off`, truncated to 8 bits.
  - `wdata` = `ram_wdata_i` << (8·`off`).
  - `ram_rdata_o` = `rdata` >> (8·`off`), zero-filled from the top.
  - Accesses that cross the 8-byte line are not supported; upper bytes are dropped.
- `axi_busy_o` = 1 in every state except IDLE, including DONE, so that the memory stage does not re-issue while the pipeline advances.
- `rresp` and `bresp` are ignored unless `LSU_AXI_ERR_EN` is defined.

## Timing
- Reset values:
  - state = IDLE.
  - All valid/ready outputs = 0.
  - `ram_rdata_o` = 0, `axi_busy_o` = 0, `done_o` = 0, `err_o` = 0.
  - All address, data and strobe outputs = 0.
- Every output is a register or is decoded from the state register; there are no combinational paths from AXI inputs to AXI outputs.
- Minimum latency with zero-wait slaves, counted from the IDLE sample edge:
  - Load: RD_ADDR 1 + RD_DATA 1 + DONE, so `done_o` is high in cycle 3.
  - Store: WR_ADDR_DATA 1 + WR_RESP 1 + DONE, so `done_o` is high in cycle 3.
  - Combined store + load: `done_o` is high in cycle 5.
- Valid signals never drop before their ready is seen (AXI rule). Address, data and strobes stay stable while valid is high.
- Requests that arrive while not in IDLE are ignored. The upstream stage gates them with `axi_busy_o`.
- `rst` asserted mid-transaction:
  - Immediate return to IDLE with all valids deasserted.
  - The outstanding AXI transaction is abandoned; the interconnect is reset by the same `rst`.

## Configuration
- `LSU_AXI_ERR_EN` defined:
  - Adds the `err_o` port.
  - `err_o` sets on a handshake with `rresp` ≠ 0 or `bresp` ≠ 0 and stays set until `rst`.
  - The transaction still completes normally, and read data is captured regardless of `rresp`.
- `LSU_AXI_ERR_EN` undefined: no `err_o` port and no error register; response codes are ignored.

## Test plan
- Load, zero-wait slave: `ram_raddr_i` = 0x8000_0004, slave `rdata` = 0x1122_3344_5566_7788 → `araddr` = 0x8000_0000; `ram_rdata_o` = 0x0000_0000_1122_3344; `done_o` high in cycle 3; `axi_busy_o` high in cycles 1–3.
- Byte store with offset: `ram_waddr_i` = 0x8000_0013, wdata 0xAB, wmask 0xff → `awaddr` = 0x8000_0010, `wstrb` = 0x08, `wdata` = 0x0000_0000_AB00_0000.
- Skewed ready: `awready` at +1 and `wready` at +4 → WR_RESP entered only after the `wready` handshake; `awvalid` low from +2 while `wvalid` stays high until +4.
- Combined request: `ram_wen_i` = `ram_ren_i` = 1 at the same address → AW/W/B complete before `arvalid` asserts; a single `done_o` pulse in cycle 5.
- Reset in RD_DATA with `rvalid` held low → after `rst`: state IDLE, `arvalid` = `rready` = 0, `axi_busy_o` = 0, `ram_rdata_o` = 0.
- With `LSU_AXI_ERR_EN`: `bresp` = 2'b10 → `err_o` = 1 from the cycle after the B handshake and remains 1 across a following clean load.
